// File: rtl/cr_ram_r_w_2c.sv
// Simple dual-port RAM: one write port, one read port with independent clocks.
// Read is either combinational (pAsyncRead=1) or registered on RdEn (pAsyncRead=0).
module cr_ram_r_w_2c #(
  parameter int unsigned pWidth     = 8,
  parameter int unsigned pAddrSize  = 4,
  parameter bit          pAsyncRead = 1'b0
) (
  input  logic                 WrClk,
  input  logic                 WrEn,
  input  logic [pAddrSize-1:0] WrAddr,
  input  logic [pWidth-1:0]    WrData,
  input  logic                 RdClk,
  input  logic                 RdEn,
  input  logic [pAddrSize-1:0] RdAddr,
  output logic [pWidth-1:0]    RdData
);

  localparam int unsigned DEPTH = 2 ** pAddrSize;

  logic [pWidth-1:0] mem_q [DEPTH];

  always_ff @(posedge WrClk) begin
    if (WrEn) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  generate
    if (pAsyncRead) begin : g_async_rd
      assign RdData = mem_q[RdAddr];
    end else begin : g_sync_rd
      logic [pWidth-1:0] rd_data_d;
      logic [pWidth-1:0] rd_data_q;

      // Read register holds its value while RdEn is low; the FIFO relies on
      // this to keep OutData stable during consumer stalls.
      always_comb begin
        rd_data_d = rd_data_q;
        if (RdEn) begin
          rd_data_d = mem_q[RdAddr];
        end
      end

      always_ff @(posedge RdClk) begin
        rd_data_q <= rd_data_d;
      end

      assign RdData = rd_data_q;
    end
  endgenerate

endmodule

// File: rtl/cr_fifo_r_w_1c.sv
// Single-clock ready/valid FIFO controller around cr_ram_r_w_2c; the RAM read
// register doubles as the output holding register, so capacity is DEPTH+1.
module cr_fifo_r_w_1c #(
  parameter int unsigned pWidth      = 8,
  parameter int unsigned pAddrSize   = 4,
  parameter int unsigned pAlmostFull = 14
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [pWidth-1:0]    InData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [pWidth-1:0]    OutData,
  output logic [pAddrSize:0]   Level,
  output logic                 AlmostFull,
  output logic                 Empty
);

  localparam int unsigned DEPTH = 2 ** pAddrSize;
  localparam int unsigned PTR_W = pAddrSize + 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(pAlmostFull);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic             out_valid_d, out_valid_q;

  logic [PTR_W-1:0] ram_count;
  logic [PTR_W-1:0] level;
  logic             in_ready;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB separates full (count == DEPTH) from empty (count == 0).
  always_comb begin
    ram_count   = wr_ptr_q - rd_ptr_q;
    in_ready    = (ram_count != DEPTH_CNT);
    push        = InValid & in_ready;
    pop         = out_valid_q & OutReady;
    wr_en       = push & ~Rst;
    rd_en       = (ram_count != '0) & (~out_valid_q | OutReady) & ~Rst;
    level       = ram_count + PTR_W'(out_valid_q);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  cr_ram_r_w_2c #(
    .pWidth     (pWidth),
    .pAddrSize  (pAddrSize),
    .pAsyncRead (1'b0)
  ) u_ram (
    .WrClk  (Clk),
    .WrEn   (wr_en),
    .WrAddr (wr_ptr_q[pAddrSize-1:0]),
    .WrData (InData),
    .RdClk  (Clk),
    .RdEn   (rd_en),
    .RdAddr (rd_ptr_q[pAddrSize-1:0]),
    .RdData (OutData)
  );

  assign InReady    = in_ready;
  assign OutValid   = out_valid_q;
  assign Level      = level;
  assign Empty      = (level == '0);
  assign AlmostFull = (level >= AF_LVL);

endmodule

// File: tb/tb_cr_fifo_r_w_1c.sv
// Bench for cr_fifo_r_w_1c at DEPTH=4 (capacity 5), AlmostFull at Level 4,
// checked against a queue-based model of RAM contents plus output register.
module tb_cr_fifo_r_w_1c;

  localparam int unsigned W  = 8;
  localparam int unsigned AS = 2;
  localparam int unsigned AF = 4;
  localparam int unsigned RAM_DEPTH = 4;

  logic          clk = 1'b0;
  logic          Rst = 1'b1;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [W-1:0]  InData = '0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [W-1:0]  OutData;
  logic [AS:0]   Level;
  logic          AlmostFull;
  logic          Empty;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_ram[$];
  bit           m_ov = 1'b0;
  logic [W-1:0] m_od = '0;
  int           got[$];

  always #5 clk = ~clk;

  cr_fifo_r_w_1c #(
    .pWidth      (W),
    .pAddrSize   (AS),
    .pAlmostFull (AF)
  ) dut (
    .Clk        (clk),
    .Rst        (Rst),
    .InValid    (InValid),
    .InReady    (InReady),
    .InData     (InData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutData    (OutData),
    .Level      (Level),
    .AlmostFull (AlmostFull),
    .Empty      (Empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_level();
    return m_ram.size() + int'(m_ov);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".InReady"},    32'(InReady),    32'(m_ram.size() != RAM_DEPTH));
    chk({tag, ".OutValid"},   32'(OutValid),   32'(m_ov));
    chk({tag, ".Level"},      32'(Level),      32'(m_level()));
    chk({tag, ".Empty"},      32'(Empty),      32'(m_level() == 0));
    chk({tag, ".AlmostFull"}, 32'(AlmostFull), 32'(m_level() >= AF));
    if (m_ov) chk({tag, ".OutData"}, 32'(OutData), 32'(m_od));
  endtask

  // Drive one cycle's inputs at negedge, advance the model at posedge,
  // then compare all outputs just after the edge.
  task automatic step(input bit rst, input bit v, input logic [W-1:0] d,
                      input bit rdy, input string tag);
    bit m_push, m_rden, m_pop;
    @(negedge clk);
    Rst = rst; InValid = v; InData = d; OutReady = rdy;
    #1;
    if (!rst && OutValid && rdy) got.push_back(int'(OutData));
    @(posedge clk);
    if (rst) begin
      m_ram.delete();
      m_ov = 1'b0;
    end else begin
      m_push = v && (m_ram.size() != RAM_DEPTH);
      m_rden = (m_ram.size() != 0) && (!m_ov || rdy);
      m_pop  = m_ov && rdy;
      if (m_rden) begin
        m_od = m_ram.pop_front();
        m_ov = 1'b1;
      end else if (m_pop) begin
        m_ov = 1'b0;
      end
      if (m_push) m_ram.push_back(d);
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int send;
    int cyc;
    bit v, rdy, acc;

    step(1, 0, '0, 0, "rst");
    step(1, 0, '0, 0, "rst");
    chk("rst_inready", 32'(InReady), 32'd1);
    chk("rst_level",   32'(Level),   32'd0);
    chk("rst_empty",   32'(Empty),   32'd1);
    chk("rst_af",      32'(AlmostFull), 32'd0);
    chk("rst_ovalid",  32'(OutValid), 32'd0);

    step(0, 1, 8'hA1, 0, "lat_push");
    chk("lat_edge1_ovalid", 32'(OutValid), 32'd0);
    step(0, 0, '0, 0, "lat_wait");
    chk("lat_edge2_ovalid", 32'(OutValid), 32'd1);
    chk("lat_edge2_odata",  32'(OutData),  32'hA1);
    chk("lat_edge2_level",  32'(Level),    32'd1);
    chk("lat_edge2_empty",  32'(Empty),    32'd0);

    step(1, 0, '0, 0, "rst");
    got.delete();
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, W'(i), 0, "fill");
      if (i == 3) chk("fill3_af", 32'(AlmostFull), 32'd0);
      if (i == 4) chk("fill4_af", 32'(AlmostFull), 32'd1);
    end
    chk("full_inready", 32'(InReady), 32'd0);
    chk("full_level",   32'(Level),   32'd5);
    chk("full_af",      32'(AlmostFull), 32'd1);
    step(0, 1, 8'h06, 0, "full_reject");
    chk("reject_level", 32'(Level), 32'd5);
    step(0, 0, '0, 1, "pop1");
    chk("pop1_inready", 32'(InReady), 32'd1);
    chk("pop1_level",   32'(Level),   32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, "drain");
    chk("drain_count_gapless", 32'(got.size()), 32'd5);
    step(0, 0, '0, 1, "drain_tail");
    chk("drain_empty",  32'(Empty),    32'd1);
    chk("drain_ovalid", 32'(OutValid), 32'd0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("drain_word%0d", i), 32'(got[i]), 32'(i + 1));

    step(1, 0, '0, 0, "rst");
    got.delete();
    send = 0;
    cyc = 0;
    while (got.size() < 40 && cyc < 600) begin
      v   = (send < 40);
      rdy = ($urandom_range(0, 3) != 0);
      acc = v && (m_ram.size() != RAM_DEPTH);
      step(0, v, W'(send), rdy, "stream");
      if (acc) send++;
      cyc++;
    end
    chk("stream_count", 32'(got.size()), 32'd40);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("stream_word%0d", i), 32'(got[i]), 32'(i));

    step(1, 0, '0, 0, "rst");
    got.delete();
    step(0, 1, 8'h31, 0, "lvl3_fill");
    step(0, 1, 8'h32, 0, "lvl3_fill");
    step(0, 1, 8'h33, 0, "lvl3_fill");
    chk("lvl3_before", 32'(Level), 32'd3);
    step(0, 1, 8'h34, 1, "lvl3_pushpop");
    chk("lvl3_after", 32'(Level), 32'd3);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, "lvl3_drain");
    chk("lvl3_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("lvl3_word%0d", i), 32'(got[i]), 32'(8'h31 + i));

    step(1, 0, '0, 0, "rst");
    step(0, 1, 8'h71, 0, "rstmid_fill");
    step(0, 1, 8'h72, 0, "rstmid_fill");
    step(0, 1, 8'h73, 0, "rstmid_fill");
    step(1, 1, 8'h77, 0, "rstmid_rst");
    chk("rstmid_level",   32'(Level),    32'd0);
    chk("rstmid_ovalid",  32'(OutValid), 32'd0);
    chk("rstmid_inready", 32'(InReady),  32'd1);
    step(0, 1, 8'h5A, 0, "rstmid_push");
    step(0, 0, '0, 0, "rstmid_wait");
    chk("rstmid_first_valid", 32'(OutValid), 32'd1);
    chk("rstmid_first_data",  32'(OutData),  32'h5A);
    chk("rstmid_first_level", 32'(Level),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
